mover_sequencer: RTL and testbench
==================================

Name: mover_sequencer

Overview:
Parametrised DataMover command/status sequencer for the stream-to-DDR capture path. It issues a run of fixed-size S2MM commands, then optionally a run of MM2S commands, covering one contiguous DDR region. It supports selectable direction modes, several commands in flight per direction, and status decode with error and tag checking. It sits between the top-level capture control and the AXI DataMover CMD/STS ports.

Parameters:
ADDR_W, 32, DDR byte-address width; command word width CMD_W = ADDR_W+40.
BTT_W, 23, bytes-to-transfer field width.
BASE_ADDR, 0, first DDR byte address of the region.
XFER_BYTES, 2**28, bytes per direction per run; must be a multiple of CHUNK_BYTES (elaboration error otherwise).
CHUNK_BYTES, 4096, BTT per command; must be > 0 and < 2**BTT_W.
MAX_OUTSTANDING, 2, maximum commands issued without status returned, per direction (1..15).
S2MM_TAG, 4'hA, tag placed in S2MM commands and expected back in S2MM status.
MM2S_TAG, 4'hB, tag for MM2S commands and status.
RESET_HOLD, 16, cycles that cmdsts_aresetn stays low after reset deasserts.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high.
start  in  1  level; sampled in IDLE.
mode  in  2  01 S2MM only, 10 MM2S only, 11 S2MM then MM2S, 00 no-op; latched on start.
busy  out  1  high in any state except IDLE/HOLD.
done  out  1  high in IDLE only.
error  out  1  sticky; set on bad status; cleared on the next accepted start.
err_status  out  8  status byte that caused error; 0 when error=0.
cmd_count  out  BTT_W  commands completed in the current direction.
m_axis_s2mm_cmdsts_aresetn  out  1  DataMover S2MM cmd/sts reset.
S_AXIS_S2MM_CMD_tdata  out  CMD_W  {4'b0, tag, addr, 8'b0, 1'b1 (INCR), BTT}.
S_AXIS_S2MM_CMD_tvalid  out  1
S_AXIS_S2MM_CMD_tready  in  1
M_AXIS_S2MM_STS_tdata  in  8
M_AXIS_S2MM_STS_tvalid  in  1
M_AXIS_S2MM_STS_tready  out  1
m_axis_mm2s_cmdsts_aresetn, S_AXIS_MM2S_CMD_*, M_AXIS_MM2S_STS_*: same as the S2MM set.

Behaviour:
- Reset (async assert, sync release): both aresetn=0, every tvalid=0, done=0, busy=0, error=0, err_status=0, cmd_count=0, state HOLD.
- Hold counter releases aresetn RESET_HOLD cycles after reset falls. HOLD exits to IDLE 2*RESET_HOLD cycles after reset falls.
- IDLE: done=1. When start=1, latch mode, clear error, err_status and counters, then go to the first enabled direction. With mode=00, stay in IDLE and still clear error.
- RUN_S2MM / RUN_MM2S use an issue index i, a completion count c and an outstanding count o.
  - Command: tvalid=1 while i < N (N = XFER_BYTES/CHUNK_BYTES) and o < MAX_OUTSTANDING.
  - tdata: addr = BASE_ADDR + i*CHUNK_BYTES, mod 2**ADDR_W, wraps silently. tdata is registered and holds stable while tvalid=1 && !tready.
  - Handshake (tvalid&tready): i++ and o++.
  - Status: tready=1 always. Each beat gives c++ and o--. A command handshake and a status beat in the same cycle leave o unchanged.
  - Status check: OKAY=bit7, INTERR=bit4, DECERR=bit5, SLVERR=bit6. A beat is bad if bit7=0, any of bits 6:4 =1, or bits 3:0 != the direction's tag. The first bad beat sets error and err_status, and the FSM enters DRAIN.
  - When c==N: S2MM goes to MM2S if mode[1]=1, else IDLE. MM2S goes to IDLE. Counters clear on each transition.
- DRAIN: no new commands. Any tvalid already asserted stays asserted until its handshake (AXIS rule). Stay until o==0, then IDLE; error stays asserted.
- cmd_count = c of the active direction; holds its final value in IDLE.
- start is ignored outside IDLE.
- Reset mid-run: immediate return to reset values, and the DataMover is reset again through aresetn.

Test Plan:
- Reset release, RESET_HOLD=16 -> aresetn rises 16 cycles after reset falls, done rises at cycle 32, all tvalid=0 throughout.
- XFER_BYTES=16384, CHUNK=4096, mode=11, ready always high, status 8'h8A/8'h8B returned 5 cycles after each command -> S2MM addresses 0,0x1000,0x2000,0x3000, then the same four for MM2S; done returns; error=0; cmd_count=4.
- MAX_OUTSTANDING=2, status withheld -> exactly 2 commands issued (0x0, 0x1000), tvalid drops; one status beat -> third command (0x2000) issued on the next cycle.
- Second S2MM status = 8'hCA (SLVERR) -> error=1, err_status=8'hCA, no further commands, IDLE once outstanding drains; next start with mode=01 clears error.
- Status 8'h8B received during S2MM (tag mismatch) -> error=1, err_status=8'h8B.
- BASE_ADDR=32'hFFFF_F000, N=2 -> addresses 0xFFFF_F000 then 0x0000_0000; reset asserted mid-run -> all tvalid=0 and aresetn=0 immediately.

Source files
------------

// File: rtl/mover_sequencer.sv
// mover_sequencer
// Command/status sequencer for an AXI DataMover on the stream-to-DDR capture
// path. One run walks a contiguous DDR region in CHUNK_BYTES commands, first
// on S2MM and optionally on MM2S. Up to MAX_OUTSTANDING commands may be
// waiting for status in the active direction. Every returned status byte is
// checked for errors and for the expected tag.
//
// Ports
//   clk, reset                       clock, async active-high reset
//   start, mode[1:0]                 run request (level, sampled in IDLE), direction select
//   busy, done                       running / idle indicators
//   error, err_status[7:0]           sticky error flag and the status byte that caused it
//   cmd_count[BTT_W-1:0]             completed commands in the active direction
//   m_axis_{s2mm,mm2s}_cmdsts_aresetn  DataMover cmd/sts resets
//   S_AXIS_{S2MM,MM2S}_CMD_*         command streams (this block is the master)
//   M_AXIS_{S2MM,MM2S}_STS_*         status streams (this block is the slave)
//
// States
//   HOLD      | DataMover held in reset, then allowed to settle
//   IDLE      | done=1, waiting for start
//   RUN_S2MM  | issuing S2MM commands and collecting status
//   RUN_MM2S  | issuing MM2S commands and collecting status
//   DRAIN     | bad status seen; finish pending handshakes and outstanding status
module mover_sequencer #(
  parameter int              ADDR_W          = 32,
  parameter int              BTT_W           = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int              XFER_BYTES      = 268435456,
  parameter int              CHUNK_BYTES     = 4096,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [3:0]      S2MM_TAG        = 4'hA,
  parameter logic [3:0]      MM2S_TAG        = 4'hB,
  parameter int              RESET_HOLD      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [7:0]           err_status,
  output logic [BTT_W-1:0]     cmd_count,

  output logic                 m_axis_s2mm_cmdsts_aresetn,
  output logic [ADDR_W+39:0]   S_AXIS_S2MM_CMD_tdata,
  output logic                 S_AXIS_S2MM_CMD_tvalid,
  input  logic                 S_AXIS_S2MM_CMD_tready,
  input  logic [7:0]           M_AXIS_S2MM_STS_tdata,
  input  logic                 M_AXIS_S2MM_STS_tvalid,
  output logic                 M_AXIS_S2MM_STS_tready,

  output logic                 m_axis_mm2s_cmdsts_aresetn,
  output logic [ADDR_W+39:0]   S_AXIS_MM2S_CMD_tdata,
  output logic                 S_AXIS_MM2S_CMD_tvalid,
  input  logic                 S_AXIS_MM2S_CMD_tready,
  input  logic [7:0]           M_AXIS_MM2S_STS_tdata,
  input  logic                 M_AXIS_MM2S_STS_tvalid,
  output logic                 M_AXIS_MM2S_STS_tready
);

  localparam int N_CMDS = (CHUNK_BYTES > 0) ? (XFER_BYTES / CHUNK_BYTES) : 1;
  localparam int CNT_W  = (N_CMDS > 0) ? $clog2(N_CMDS + 1) : 1;
  localparam int HOLD_W = $clog2(2 * RESET_HOLD + 2);

  localparam logic [CNT_W-1:0]  N_C      = CNT_W'(N_CMDS);
  localparam logic [3:0]        MAXO_C   = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] CHUNK_A  = ADDR_W'(CHUNK_BYTES);
  // The DataMover BTT field is always 23 bits wide; narrower BTT_W is zero-extended.
  localparam logic [22:0]       BTT_F    = 23'(CHUNK_BYTES);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(2 * RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_REL  = HOLD_W'(RESET_HOLD + 1);

  if (CHUNK_BYTES <= 0) begin : g_chk_chunk_pos
    $error("mover_sequencer: CHUNK_BYTES must be > 0");
  end
  if (BTT_W > 23 || BTT_W < 1) begin : g_chk_btt_w
    $error("mover_sequencer: BTT_W must be 1..23");
  end
  if (longint'(CHUNK_BYTES) >= (64'd1 << BTT_W)) begin : g_chk_chunk_max
    $error("mover_sequencer: CHUNK_BYTES must be < 2**BTT_W");
  end
  if (XFER_BYTES <= 0 || (CHUNK_BYTES > 0 && (XFER_BYTES % CHUNK_BYTES) != 0)) begin : g_chk_xfer
    $error("mover_sequencer: XFER_BYTES must be a positive multiple of CHUNK_BYTES");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_chk_maxo
    $error("mover_sequencer: MAX_OUTSTANDING must be 1..15");
  end
  if (RESET_HOLD < 1) begin : g_chk_hold
    $error("mover_sequencer: RESET_HOLD must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RUN_S2MM = 3'd2,
    ST_RUN_MM2S = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic [HOLD_W-1:0]  r_hold, w_hold_n;
  logic               r_aresetn, w_aresetn_n;
  logic [CNT_W-1:0]   r_i, w_i_n;
  logic [CNT_W-1:0]   r_c, w_c_n;
  logic [3:0]         r_o, w_o_n;
  logic [ADDR_W-1:0]  r_addr, w_addr_n;
  logic               r_dir, w_dir_n;          // 0 = S2MM active, 1 = MM2S active
  logic               r_mm2s_next, w_mm2s_next_n;
  logic               r_error, w_error_n;
  logic [7:0]         r_err_status, w_err_status_n;
  logic               r_s2mm_valid, w_s2mm_valid_n;
  logic               r_mm2s_valid, w_mm2s_valid_n;

  logic               w_cmd_hs;
  logic               w_pend;
  logic               w_sts_v;
  logic [7:0]         w_sts_d;
  logic [3:0]         w_sts_tag;
  logic               w_sts_bad;
  logic [3:0]         w_o_upd;

  // Only one direction is ever active, so its valid alone identifies the handshake.
  assign w_cmd_hs = (r_s2mm_valid & S_AXIS_S2MM_CMD_tready) |
                    (r_mm2s_valid & S_AXIS_MM2S_CMD_tready);
  assign w_pend   = (r_s2mm_valid & ~S_AXIS_S2MM_CMD_tready) |
                    (r_mm2s_valid & ~S_AXIS_MM2S_CMD_tready);

  assign w_sts_v   = r_dir ? M_AXIS_MM2S_STS_tvalid : M_AXIS_S2MM_STS_tvalid;
  assign w_sts_d   = r_dir ? M_AXIS_MM2S_STS_tdata  : M_AXIS_S2MM_STS_tdata;
  assign w_sts_tag = r_dir ? MM2S_TAG : S2MM_TAG;
  assign w_sts_bad = ~w_sts_d[7] | (|w_sts_d[6:4]) | (w_sts_d[3:0] != w_sts_tag);

  // A command handshake and a status beat in the same cycle cancel out.
  always_comb begin
    w_o_upd = r_o;
    if (w_cmd_hs && !w_sts_v) begin
      w_o_upd = r_o + 4'd1;
    end else if (!w_cmd_hs && w_sts_v && r_o != 4'd0) begin
      w_o_upd = r_o - 4'd1;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_hold_n       = r_hold;
    w_aresetn_n    = r_aresetn;
    w_i_n          = r_i;
    w_c_n          = r_c;
    w_o_n          = r_o;
    w_addr_n       = r_addr;
    w_dir_n        = r_dir;
    w_mm2s_next_n  = r_mm2s_next;
    w_error_n      = r_error;
    w_err_status_n = r_err_status;
    w_s2mm_valid_n = 1'b0;
    w_mm2s_valid_n = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (r_hold != '0) begin
          w_hold_n = r_hold - 1'b1;
        end
        if (r_hold <= HOLD_REL) begin
          w_aresetn_n = 1'b1;
        end
        if (r_hold <= HOLD_W'(1)) begin
          w_state_n = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (start) begin
          w_mm2s_next_n  = mode[1];
          w_error_n      = 1'b0;
          w_err_status_n = 8'h00;
          w_i_n          = '0;
          w_c_n          = '0;
          w_o_n          = '0;
          w_addr_n       = BASE_ADDR;
          if (mode[0]) begin
            w_state_n = ST_RUN_S2MM;
            w_dir_n   = 1'b0;
          end else if (mode[1]) begin
            w_state_n = ST_RUN_MM2S;
            w_dir_n   = 1'b1;
          end
        end
      end

      ST_RUN_S2MM, ST_RUN_MM2S: begin
        if (w_cmd_hs) begin
          w_i_n    = r_i + 1'b1;
          w_addr_n = r_addr + CHUNK_A;   // wraps modulo 2**ADDR_W
        end
        w_o_n = w_o_upd;
        if (w_sts_v) begin
          w_c_n = r_c + 1'b1;
        end
        if (w_sts_v && w_sts_bad) begin
          w_error_n      = 1'b1;
          w_err_status_n = w_sts_d;
          w_state_n      = ST_DRAIN;
        end else if (w_c_n == N_C) begin
          w_i_n    = '0;
          w_o_n    = '0;
          w_addr_n = BASE_ADDR;
          if (r_state == ST_RUN_S2MM && r_mm2s_next) begin
            w_state_n = ST_RUN_MM2S;
            w_dir_n   = 1'b1;
            w_c_n     = '0;
          end else begin
            // c is kept so cmd_count shows the final total while idle.
            w_state_n = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (w_cmd_hs) begin
          w_i_n    = r_i + 1'b1;
          w_addr_n = r_addr + CHUNK_A;
        end
        w_o_n = w_o_upd;
        if (w_sts_v) begin
          w_c_n = r_c + 1'b1;
        end
        if (w_o_n == 4'd0 && !w_pend) begin
          w_state_n = ST_IDLE;
        end
      end

      default: begin
        w_state_n = ST_HOLD;
      end
    endcase

    // Issue window while running; in DRAIN only an unaccepted command may stay up.
    if (w_state_n == ST_RUN_S2MM) begin
      w_s2mm_valid_n = (w_i_n < N_C) && (w_o_n < MAXO_C);
    end else if (w_state_n == ST_DRAIN) begin
      w_s2mm_valid_n = r_s2mm_valid && !S_AXIS_S2MM_CMD_tready;
    end
    if (w_state_n == ST_RUN_MM2S) begin
      w_mm2s_valid_n = (w_i_n < N_C) && (w_o_n < MAXO_C);
    end else if (w_state_n == ST_DRAIN) begin
      w_mm2s_valid_n = r_mm2s_valid && !S_AXIS_MM2S_CMD_tready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_HOLD;
      r_hold       <= HOLD_INIT;
      r_aresetn    <= 1'b0;
      r_i          <= '0;
      r_c          <= '0;
      r_o          <= '0;
      r_addr       <= BASE_ADDR;
      r_dir        <= 1'b0;
      r_mm2s_next  <= 1'b0;
      r_error      <= 1'b0;
      r_err_status <= 8'h00;
      r_s2mm_valid <= 1'b0;
      r_mm2s_valid <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_hold       <= w_hold_n;
      r_aresetn    <= w_aresetn_n;
      r_i          <= w_i_n;
      r_c          <= w_c_n;
      r_o          <= w_o_n;
      r_addr       <= w_addr_n;
      r_dir        <= w_dir_n;
      r_mm2s_next  <= w_mm2s_next_n;
      r_error      <= w_error_n;
      r_err_status <= w_err_status_n;
      r_s2mm_valid <= w_s2mm_valid_n;
      r_mm2s_valid <= w_mm2s_valid_n;
    end
  end

  assign busy       = (r_state != ST_IDLE) && (r_state != ST_HOLD);
  assign done       = (r_state == ST_IDLE);
  assign error      = r_error;
  assign err_status = r_err_status;
  assign cmd_count  = BTT_W'(r_c);

  assign m_axis_s2mm_cmdsts_aresetn = r_aresetn;
  assign m_axis_mm2s_cmdsts_aresetn = r_aresetn;

  // tdata only moves on a handshake (r_addr), so it is stable while waiting for tready.
  assign S_AXIS_S2MM_CMD_tdata  = {4'b0000, S2MM_TAG, r_addr, 8'h00, 1'b1, BTT_F};
  assign S_AXIS_MM2S_CMD_tdata  = {4'b0000, MM2S_TAG, r_addr, 8'h00, 1'b1, BTT_F};
  assign S_AXIS_S2MM_CMD_tvalid = r_s2mm_valid;
  assign S_AXIS_MM2S_CMD_tvalid = r_mm2s_valid;

  assign M_AXIS_S2MM_STS_tready = 1'b1;
  assign M_AXIS_MM2S_STS_tready = 1'b1;

endmodule

// File: tb/tb_mover_sequencer.sv
module tb_mover_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: BASE 0, N=4
  logic        a_start;
  logic [1:0]  a_mode;
  logic        a_busy, a_done, a_error;
  logic [7:0]  a_err_status;
  logic [22:0] a_cmd_count;
  logic        a_s_arst, a_m_arst;
  logic [71:0] a_s_cd, a_m_cd;
  logic        a_s_cv, a_m_cv, a_s_crdy, a_m_crdy;
  logic [7:0]  a_s_sd, a_m_sd;
  logic        a_s_sv, a_m_sv, a_s_srdy, a_m_srdy;

  // DUT B: BASE 0xFFFF_F000, N=2, short hold
  logic        b_start;
  logic [1:0]  b_mode;
  logic        b_busy, b_done, b_error;
  logic [7:0]  b_err_status;
  logic [22:0] b_cmd_count;
  logic        b_s_arst, b_m_arst;
  logic [71:0] b_s_cd, b_m_cd;
  logic        b_s_cv, b_m_cv, b_s_crdy, b_m_crdy;
  logic [7:0]  b_s_sd, b_m_sd;
  logic        b_s_sv, b_m_sv, b_s_srdy, b_m_srdy;

  mover_sequencer #(
    .ADDR_W(32), .BTT_W(23), .BASE_ADDR(32'h0000_0000), .XFER_BYTES(16384),
    .CHUNK_BYTES(4096), .MAX_OUTSTANDING(2), .S2MM_TAG(4'hA), .MM2S_TAG(4'hB),
    .RESET_HOLD(16)
  ) u_dut_a (
    .clk(clk), .reset(rst), .start(a_start), .mode(a_mode),
    .busy(a_busy), .done(a_done), .error(a_error), .err_status(a_err_status),
    .cmd_count(a_cmd_count),
    .m_axis_s2mm_cmdsts_aresetn(a_s_arst),
    .S_AXIS_S2MM_CMD_tdata(a_s_cd), .S_AXIS_S2MM_CMD_tvalid(a_s_cv),
    .S_AXIS_S2MM_CMD_tready(a_s_crdy),
    .M_AXIS_S2MM_STS_tdata(a_s_sd), .M_AXIS_S2MM_STS_tvalid(a_s_sv),
    .M_AXIS_S2MM_STS_tready(a_s_srdy),
    .m_axis_mm2s_cmdsts_aresetn(a_m_arst),
    .S_AXIS_MM2S_CMD_tdata(a_m_cd), .S_AXIS_MM2S_CMD_tvalid(a_m_cv),
    .S_AXIS_MM2S_CMD_tready(a_m_crdy),
    .M_AXIS_MM2S_STS_tdata(a_m_sd), .M_AXIS_MM2S_STS_tvalid(a_m_sv),
    .M_AXIS_MM2S_STS_tready(a_m_srdy)
  );

  mover_sequencer #(
    .ADDR_W(32), .BTT_W(23), .BASE_ADDR(32'hFFFF_F000), .XFER_BYTES(8192),
    .CHUNK_BYTES(4096), .MAX_OUTSTANDING(2), .S2MM_TAG(4'hA), .MM2S_TAG(4'hB),
    .RESET_HOLD(4)
  ) u_dut_b (
    .clk(clk), .reset(rst), .start(b_start), .mode(b_mode),
    .busy(b_busy), .done(b_done), .error(b_error), .err_status(b_err_status),
    .cmd_count(b_cmd_count),
    .m_axis_s2mm_cmdsts_aresetn(b_s_arst),
    .S_AXIS_S2MM_CMD_tdata(b_s_cd), .S_AXIS_S2MM_CMD_tvalid(b_s_cv),
    .S_AXIS_S2MM_CMD_tready(b_s_crdy),
    .M_AXIS_S2MM_STS_tdata(b_s_sd), .M_AXIS_S2MM_STS_tvalid(b_s_sv),
    .M_AXIS_S2MM_STS_tready(b_s_srdy),
    .m_axis_mm2s_cmdsts_aresetn(b_m_arst),
    .S_AXIS_MM2S_CMD_tdata(b_m_cd), .S_AXIS_MM2S_CMD_tvalid(b_m_cv),
    .S_AXIS_MM2S_CMD_tready(b_m_crdy),
    .M_AXIS_MM2S_STS_tdata(b_m_sd), .M_AXIS_MM2S_STS_tvalid(b_m_sv),
    .M_AXIS_MM2S_STS_tready(b_m_srdy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [71:0] a_s_log[$];
  logic [71:0] a_m_log[$];
  logic [71:0] b_s_log[$];
  int          a_s_due[$];
  int          a_m_due[$];
  logic [7:0]  a_s_vals[$];
  bit          a_auto = 1'b0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] cmd_word(input logic [3:0] tag, input logic [31:0] addr);
    return {4'h0, tag, addr, 8'h00, 1'b1, 23'd4096};
  endfunction

  // One clock: log handshakes seen before the edge, then drive status after it.
  task automatic step();
    if (a_s_cv && a_s_crdy) begin
      a_s_log.push_back(a_s_cd);
      if (a_auto) a_s_due.push_back(cyc + 5);
    end
    if (a_m_cv && a_m_crdy) begin
      a_m_log.push_back(a_m_cd);
      if (a_auto) a_m_due.push_back(cyc + 5);
    end
    if (b_s_cv && b_s_crdy) b_s_log.push_back(b_s_cd);
    @(posedge clk);
    #1;
    cyc++;
    a_s_sv = 1'b0;
    a_m_sv = 1'b0;
    if (a_s_due.size() > 0 && a_s_due[0] <= cyc) begin
      void'(a_s_due.pop_front());
      a_s_sv = 1'b1;
      a_s_sd = 8'h8A;
      if (a_s_vals.size() > 0) a_s_sd = a_s_vals.pop_front();
    end
    if (a_m_due.size() > 0 && a_m_due[0] <= cyc) begin
      void'(a_m_due.pop_front());
      a_m_sv = 1'b1;
      a_m_sd = 8'h8B;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!a_done && k < budget) begin
      step();
      k++;
    end
    check_val(tag, 72'(a_done), 72'(1'b1));
  endtask

  task automatic pulse_start_a(input logic [1:0] m);
    a_mode  = m;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  initial begin
    bit tv_seen;
    int n_at_err;
    bit err_seen;

    rst = 1'b0;
    a_start = 1'b0; a_mode = 2'b00; a_s_crdy = 1'b1; a_m_crdy = 1'b1;
    a_s_sd = 8'h00; a_s_sv = 1'b0; a_m_sd = 8'h00; a_m_sv = 1'b0;
    b_start = 1'b0; b_mode = 2'b00; b_s_crdy = 1'b1; b_m_crdy = 1'b1;
    b_s_sd = 8'h00; b_s_sv = 1'b0; b_m_sd = 8'h00; b_m_sv = 1'b0;
    #2 rst = 1'b1;

    // Reset state
    repeat (3) step();
    check_val("rst_aresetn", 72'({a_s_arst, a_m_arst}), 72'(2'b00));
    check_val("rst_tvalid", 72'({a_s_cv, a_m_cv}), 72'(2'b00));
    check_val("rst_done_busy", 72'({a_done, a_busy}), 72'(2'b00));
    check_val("rst_error", 72'({a_error, a_err_status}), 72'(9'h000));
    check_val("rst_cmd_count", 72'(a_cmd_count), 72'(0));
    check_val("rst_sts_tready", 72'({a_s_srdy, a_m_srdy}), 72'(2'b11));

    // Hold sequence after release
    tv_seen = 1'b0;
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      tv_seen |= a_s_cv | a_m_cv;
      if (k == 15) check_val("hold_aresetn_15", 72'({a_s_arst, a_m_arst}), 72'(2'b00));
      if (k == 16) check_val("hold_aresetn_16", 72'({a_s_arst, a_m_arst}), 72'(2'b11));
      if (k == 31) check_val("hold_done_31", 72'(a_done), 72'(1'b0));
      if (k == 32) check_val("hold_done_32", 72'(a_done), 72'(1'b1));
    end
    check_val("hold_no_tvalid", 72'(tv_seen), 72'(1'b0));

    // Full S2MM then MM2S run
    a_auto = 1'b1;
    pulse_start_a(2'b11);
    check_val("run_busy", 72'({a_busy, a_done}), 72'(2'b10));
    wait_done("run_done", 400);
    check_val("run_s2mm_n", 72'(a_s_log.size()), 72'(4));
    check_val("run_mm2s_n", 72'(a_m_log.size()), 72'(4));
    for (int i = 0; i < 4; i++) begin
      check_val("run_s2mm_cmd", (i < a_s_log.size()) ? a_s_log[i] : 72'(0), cmd_word(4'hA, 32'(i * 4096)));
      check_val("run_mm2s_cmd", (i < a_m_log.size()) ? a_m_log[i] : 72'(0), cmd_word(4'hB, 32'(i * 4096)));
    end
    check_val("run_error", 72'(a_error), 72'(1'b0));
    check_val("run_cmd_count", 72'(a_cmd_count), 72'(4));

    // Outstanding limit with status withheld
    a_s_log.delete(); a_m_log.delete();
    a_auto = 1'b0;
    pulse_start_a(2'b01);
    repeat (8) step();
    check_val("ost_n_issued", 72'(a_s_log.size()), 72'(2));
    check_val("ost_cmd0", (a_s_log.size() > 0) ? a_s_log[0] : 72'(0), cmd_word(4'hA, 32'h0000));
    check_val("ost_cmd1", (a_s_log.size() > 1) ? a_s_log[1] : 72'(0), cmd_word(4'hA, 32'h1000));
    check_val("ost_tvalid_low", 72'(a_s_cv), 72'(1'b0));
    a_s_sv = 1'b1;
    a_s_sd = 8'h8A;
    step();
    check_val("ost_tvalid_again", 72'(a_s_cv), 72'(1'b1));
    check_val("ost_cmd2", a_s_cd, cmd_word(4'hA, 32'h2000));
    check_val("ost_count1", 72'(a_cmd_count), 72'(1));
    a_s_due.push_back(cyc);
    a_auto = 1'b1;
    wait_done("ost_done", 200);
    check_val("ost_total", 72'(a_s_log.size()), 72'(4));
    check_val("ost_cmd_count", 72'(a_cmd_count), 72'(4));

    // SLVERR on the second status
    a_s_log.delete();
    a_s_vals.push_back(8'h8A);
    a_s_vals.push_back(8'hCA);
    pulse_start_a(2'b01);
    err_seen = 1'b0;
    n_at_err = 0;
    for (int k = 0; k < 200 && !(err_seen && a_done); k++) begin
      step();
      if (a_error && !err_seen) begin
        err_seen = 1'b1;
        n_at_err = a_s_log.size();
      end
    end
    check_val("slv_done", 72'({err_seen, a_done}), 72'(2'b11));
    check_val("slv_error", 72'(a_error), 72'(1'b1));
    check_val("slv_err_status", 72'(a_err_status), 72'(8'hCA));
    check_val("slv_cmds_at_err", 72'(n_at_err), 72'(3));
    check_val("slv_no_more_cmds", 72'(a_s_log.size()), 72'(3));
    pulse_start_a(2'b01);
    check_val("slv_clear", 72'({a_error, a_err_status}), 72'(9'h000));
    wait_done("slv_rerun_done", 200);
    check_val("slv_rerun_count", 72'({a_error, a_cmd_count}), 72'({1'b0, 23'd4}));

    // Tag mismatch on S2MM
    a_s_vals.push_back(8'h8B);
    pulse_start_a(2'b01);
    wait_done("tag_done", 200);
    check_val("tag_error", 72'({a_error, a_err_status}), 72'({1'b1, 8'h8B}));
    check_val("tag_cmd_count", 72'(a_cmd_count), 72'(2));

    // mode=00 clears error and stays idle
    pulse_start_a(2'b00);
    check_val("nop_state", 72'({a_error, a_err_status, a_done, a_busy}), 72'({1'b0, 8'h00, 1'b1, 1'b0}));

    // Address wrap and reset mid-run on DUT B
    b_mode  = 2'b01;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check_val("wrap_cmd0", b_s_cd, cmd_word(4'hA, 32'hFFFF_F000));
    step();
    b_s_crdy = 1'b0;
    step();
    step();
    check_val("wrap_cmd1_held", 72'({b_s_cv, b_s_cd}), 72'({1'b1, cmd_word(4'hA, 32'h0000_0000)}));
    check_val("wrap_log", (b_s_log.size() == 1) ? b_s_log[0] : 72'(0), cmd_word(4'hA, 32'hFFFF_F000));
    #2 rst = 1'b1;
    #1;
    check_val("midrst_tvalid", 72'({b_s_cv, b_m_cv, a_s_cv, a_m_cv}), 72'(4'b0000));
    check_val("midrst_aresetn", 72'({b_s_arst, b_m_arst, a_s_arst}), 72'(3'b000));
    check_val("midrst_flags", 72'({b_busy, b_done}), 72'(2'b00));
    rst = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
